// File: rtl/video_mode_sequencer_if.sv
// Signal bundle between the config command source / video PLL blocks and the
// video mode sequencer.
interface video_mode_sequencer_if;
    logic [7:0] data_in;
    logic       reconf_ack;
    logic       pll_locked;
    logic [1:0] mode_sel;
    logic       reconf_req;
    logic [1:0] reconf_mode;
    logic       video_reset;
    logic       blank;
    logic       busy;
    logic       lock_error;

    modport slave (
        input  data_in, reconf_ack, pll_locked,
        output mode_sel, reconf_req, reconf_mode, video_reset, blank, busy, lock_error
    );

    modport master (
        output data_in, reconf_ack, pll_locked,
        input  mode_sel, reconf_req, reconf_mode, video_reset, blank, busy, lock_error
    );
endinterface

// File: rtl/video_mode_sequencer.sv
// Sequences a video mode change: qualify the command, blank and hold timing in
// reset, reconfigure the pixel PLL, wait for lock plus settle, then publish.
`ifndef MODE_VGA
`define MODE_VGA 8'h01
`endif
`ifndef MODE_720p
`define MODE_720p 8'h02
`endif
`ifndef MODE_1080p
`define MODE_1080p 8'h03
`endif

module video_mode_sequencer #(
    parameter int         STABLE_CYCLES = 4,
    parameter int         SETTLE_CYCLES = 16,
    parameter int         LOCK_TIMEOUT  = 1048575,
    parameter logic [1:0] DEFAULT_MODE  = 2'd2
) (
    input logic                    clock,
    input logic                    reset,
    video_mode_sequencer_if.slave  bus
);

    localparam int SW = $clog2(STABLE_CYCLES + 1);
    localparam int CW = 20;

    typedef enum logic [1:0] {
        VM_VGA   = 2'd0,
        VM_720P  = 2'd1,
        VM_1080P = 2'd2
    } video_mode_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_BLANK,
        S_RECONF,
        S_WAIT_LOCK,
        S_SETTLE
    } state_e;

    // Command qualifier
    logic [7:0]    data_q;
    logic [SW-1:0] stable_cnt_q;
    logic [1:0]    pending_q;
    logic          pending_valid_q;
    logic          cmd_valid;
    logic [1:0]    cmd_idx;
    logic          accept;
    logic          consume;

    // Sequencer
    state_e        state_q, state_d;
    logic [1:0]    target_q, target_d;
    logic [1:0]    mode_sel_q, mode_sel_d;
    logic          lock_error_q, lock_error_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          lock_s1_q, lock_s2_q;

    always_comb begin
        cmd_valid = 1'b1;
        cmd_idx   = VM_VGA;
        case (data_q)
            `MODE_VGA:   cmd_idx = VM_VGA;
            `MODE_720p:  cmd_idx = VM_720P;
            `MODE_1080p: cmd_idx = VM_1080P;
            default:     cmd_valid = 1'b0;
        endcase
    end

    // Fires once, on the cycle the held value completes its stability window.
    assign accept = (bus.data_in == data_q) &&
                    (stable_cnt_q == SW'(STABLE_CYCLES - 1)) && cmd_valid;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            data_q          <= 8'h00;
            stable_cnt_q    <= '0;
            pending_q       <= DEFAULT_MODE;
            pending_valid_q <= 1'b0;
        end else begin
            data_q <= bus.data_in;
            if (bus.data_in != data_q) begin
                stable_cnt_q <= '0;
            end else if (stable_cnt_q != SW'(STABLE_CYCLES)) begin
                stable_cnt_q <= stable_cnt_q + 1'b1;
            end
            if (accept) begin
                pending_q       <= cmd_idx;
                pending_valid_q <= 1'b1;
            end else if (consume) begin
                pending_valid_q <= 1'b0;
            end
        end
    end

    // NOTE: pll_locked comes from another clock domain; two flops before use.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            lock_s1_q <= 1'b0;
            lock_s2_q <= 1'b0;
        end else begin
            lock_s1_q <= bus.pll_locked;
            lock_s2_q <= lock_s1_q;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= S_WAIT_LOCK;
            target_q     <= DEFAULT_MODE;
            mode_sel_q   <= DEFAULT_MODE;
            lock_error_q <= 1'b0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            target_q     <= target_d;
            mode_sel_q   <= mode_sel_d;
            lock_error_q <= lock_error_d;
            cnt_q        <= cnt_d;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d      = state_q;
        target_d     = target_q;
        mode_sel_d   = mode_sel_q;
        lock_error_d = lock_error_q;
        cnt_d        = cnt_q;
        consume      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (pending_valid_q) begin
                    consume = 1'b1;
                    if (pending_q != mode_sel_q) begin
                        target_d = pending_q;
                        state_d  = S_BLANK;
                        cnt_d    = '0;
                    end
                end
            end
            S_BLANK: begin
                if (cnt_q == CW'(1)) begin
                    state_d = S_RECONF;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_RECONF: begin
                if (bus.reconf_ack) begin
                    state_d = S_WAIT_LOCK;
                    cnt_d   = '0;
                end
            end
            S_WAIT_LOCK: begin
                if (lock_s2_q) begin
                    state_d = S_SETTLE;
                    cnt_d   = '0;
                end else if (cnt_q == CW'(LOCK_TIMEOUT - 1)) begin
                    // Retry the same target from the blanking step.
                    lock_error_d = 1'b1;
                    state_d      = S_BLANK;
                    cnt_d        = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_SETTLE: begin
                if (!lock_s2_q) begin
                    state_d = S_WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == CW'(SETTLE_CYCLES - 1)) begin
                    mode_sel_d   = target_q;
                    lock_error_d = 1'b0;
                    state_d      = S_IDLE;
                    cnt_d        = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.busy        = (state_q != S_IDLE);
    assign bus.blank       = (state_q != S_IDLE);
    assign bus.video_reset = (state_q != S_IDLE);
    assign bus.reconf_req  = (state_q == S_RECONF);
    assign bus.reconf_mode = target_q;
    assign bus.mode_sel    = mode_sel_q;
    assign bus.lock_error  = lock_error_q;

endmodule

// File: tb/tb_video_mode_sequencer.sv
// Scoreboarded bench for video_mode_sequencer: expected modes are queued when a
// command is driven and compared when the DUT finishes a sequence.
`ifndef MODE_VGA
`define MODE_VGA 8'h01
`endif
`ifndef MODE_720p
`define MODE_720p 8'h02
`endif
`ifndef MODE_1080p
`define MODE_1080p 8'h03
`endif

module tb_video_mode_sequencer;

    localparam int STABLE  = 4;
    localparam int SETTLE  = 16;
    localparam int TIMEOUT = 100;

    logic clock = 1'b0;
    logic reset;

    video_mode_sequencer_if bus ();

    video_mode_sequencer #(
        .STABLE_CYCLES (STABLE),
        .SETTLE_CYCLES (SETTLE),
        .LOCK_TIMEOUT  (TIMEOUT),
        .DEFAULT_MODE  (2'd2)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int         n_checks  = 0;
    int         n_fail    = 0;
    int         req_rises = 0;
    int         ack_delay = 3;
    logic [1:0] exp_q[$];

    // PLL reconfig responder: one-cycle ack after ack_delay cycles of request.
    initial begin
        int seen;
        seen = 0;
        bus.reconf_ack = 1'b0;
        forever begin
            @(negedge clock);
            bus.reconf_ack = 1'b0;
            if (bus.reconf_req === 1'b1) begin
                seen++;
                if (seen == ack_delay) bus.reconf_ack = 1'b1;
            end else begin
                seen = 0;
            end
        end
    end

    // Scoreboard: pop on each completed sequence; check requested target.
    initial begin
        logic       prev_busy, prev_req;
        logic [1:0] e;
        prev_busy = 1'b1;
        prev_req  = 1'b0;
        forever begin
            @(negedge clock);
            if (reset !== 1'b0) begin
                prev_busy = 1'b1;
                prev_req  = 1'b0;
            end else begin
                if (bus.reconf_req === 1'b1 && !prev_req) req_rises++;
                if (bus.reconf_req === 1'b1) begin
                    n_checks++;
                    if (exp_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL reconf_mode: request with mode %0d but no sequence expected", bus.reconf_mode);
                    end else if (bus.reconf_mode !== exp_q[0]) begin
                        n_fail++;
                        $display("FAIL reconf_mode: got %0d expected %0d", bus.reconf_mode, exp_q[0]);
                    end
                end
                if (bus.busy === 1'b0 && prev_busy) begin
                    n_checks++;
                    if (exp_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL seq_done: unexpected completion, mode_sel=%0d", bus.mode_sel);
                    end else begin
                        e = exp_q.pop_front();
                        if (bus.mode_sel !== e) begin
                            n_fail++;
                            $display("FAIL seq_done: mode_sel=%0d expected %0d", bus.mode_sel, e);
                        end
                    end
                end
                prev_busy = bus.busy;
                prev_req  = bus.reconf_req;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Wait for busy (sel_busy=1) or reconf_req to reach a level; cycles counts negedges.
    task automatic wait_for(input bit sel_busy, input logic want, input int budget,
                            input string tag, output int cycles);
        logic v;
        cycles = 0;
        forever begin
            @(negedge clock);
            cycles++;
            v = sel_busy ? bus.busy : bus.reconf_req;
            if (v === want) break;
            if (cycles >= budget) begin
                n_checks++;
                n_fail++;
                $display("FAIL timeout_%s: waited %0d cycles", tag, cycles);
                break;
            end
        end
    endtask

    task automatic test_reset();
        int n, r0;
        logic [8:0] got;
        reset          = 1'b1;
        bus.data_in    = 8'h00;
        bus.pll_locked = 1'b1;
        repeat (3) @(negedge clock);
        got = {bus.mode_sel, bus.reconf_req, bus.reconf_mode, bus.video_reset, bus.blank, bus.busy, bus.lock_error};
        n_checks++;
        if (got !== 9'b10_0_10_1110) begin
            n_fail++;
            $display("FAIL reset_values: got %b expected %b", got, 9'b10_0_10_1110);
        end
        exp_q.push_back(2'd2);
        r0    = req_rises;
        reset = 1'b0;
        wait_for(1'b1, 1'b0, 60, "powerup", n);
        // 2 sync flops + 1 WAIT_LOCK decision + SETTLE cycles
        n_checks++;
        if (n !== 2 + 1 + SETTLE) begin
            n_fail++;
            $display("FAIL powerup_latency: got %0d expected %0d", n, 2 + 1 + SETTLE);
        end
        n_checks++;
        if (req_rises !== r0 || bus.blank !== 1'b0 || bus.video_reset !== 1'b0) begin
            n_fail++;
            $display("FAIL powerup_idle: req_rises=%0d blank=%b video_reset=%b expected 0 0 0",
                     req_rises - r0, bus.blank, bus.video_reset);
        end
    endtask

    task automatic test_mode_change();
        int n;
        @(negedge clock);
        bus.data_in = `MODE_VGA;
        exp_q.push_back(2'd0);
        wait_for(1'b0, 1'b1, 40, "vga_req", n);
        // STABLE+1 to accept, 1 IDLE decision, 2 BLANK
        n_checks++;
        if (n !== STABLE + 4) begin
            n_fail++;
            $display("FAIL vga_req_latency: got %0d expected %0d", n, STABLE + 4);
        end
        n_checks++;
        if (bus.blank !== 1'b1 || bus.video_reset !== 1'b1 || bus.reconf_mode !== 2'd0) begin
            n_fail++;
            $display("FAIL vga_in_reconf: blank=%b video_reset=%b reconf_mode=%0d expected 1 1 0",
                     bus.blank, bus.video_reset, bus.reconf_mode);
        end
        wait_for(1'b0, 1'b0, 20, "vga_req_drop", n);
        n_checks++;
        if (n !== 3) begin
            n_fail++;
            $display("FAIL vga_req_len: got %0d expected 3", n);
        end
        wait_for(1'b1, 1'b0, 60, "vga_done", n);
        n_checks++;
        if (n !== SETTLE + 1 || bus.mode_sel !== 2'd0) begin
            n_fail++;
            $display("FAIL vga_settle: cycles=%0d mode_sel=%0d expected %0d 0", n, bus.mode_sel, SETTLE + 1);
        end
    endtask

    task automatic test_glitch_filter();
        int n, r0;
        r0 = req_rises;
        for (int i = 0; i < 6; i++) begin
            bus.data_in = (i % 2 == 0) ? `MODE_720p : `MODE_VGA;
            repeat (2) @(negedge clock);
        end
        n_checks++;
        if (bus.busy !== 1'b0 || req_rises !== r0) begin
            n_fail++;
            $display("FAIL glitch_ignored: busy=%b req_rises=%0d expected 0 0", bus.busy, req_rises - r0);
        end
        bus.data_in = `MODE_720p;
        exp_q.push_back(2'd1);
        wait_for(1'b1, 1'b1, 30, "glitch_start", n);
        wait_for(1'b1, 1'b0, 80, "glitch_done", n);
        repeat (10) @(negedge clock);
        n_checks++;
        if (req_rises - r0 !== 1 || bus.mode_sel !== 2'd1 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL glitch_one_seq: sequences=%0d mode_sel=%0d busy=%b expected 1 1 0",
                     req_rises - r0, bus.mode_sel, bus.busy);
        end
    endtask

    task automatic test_lock_timeout();
        int n, r0;
        @(negedge clock);
        bus.pll_locked = 1'b0;
        bus.data_in    = `MODE_1080p;
        exp_q.push_back(2'd2);
        r0 = req_rises;
        wait_for(1'b0, 1'b1, 40, "to_req1", n);
        wait_for(1'b0, 1'b0, 20, "to_ack1", n);
        n = 1;
        forever begin
            @(negedge clock);
            if (bus.lock_error === 1'b1) break;
            n++;
            if (n > 3 * TIMEOUT) break;
        end
        n_checks++;
        if (n !== TIMEOUT) begin
            n_fail++;
            $display("FAIL lock_timeout_cycles: got %0d expected %0d", n, TIMEOUT);
        end
        wait_for(1'b0, 1'b1, 10, "to_req2", n);
        n_checks++;
        if (req_rises - r0 !== 2 || bus.lock_error !== 1'b1 || bus.reconf_mode !== 2'd2) begin
            n_fail++;
            $display("FAIL lock_retry: requests=%0d lock_error=%b reconf_mode=%0d expected 2 1 2",
                     req_rises - r0, bus.lock_error, bus.reconf_mode);
        end
        wait_for(1'b0, 1'b0, 20, "to_ack2", n);
        bus.pll_locked = 1'b1;
        wait_for(1'b1, 1'b0, 60, "to_done", n);
        n_checks++;
        if (bus.lock_error !== 1'b0 || bus.mode_sel !== 2'd2) begin
            n_fail++;
            $display("FAIL lock_recover: lock_error=%b mode_sel=%0d expected 0 2", bus.lock_error, bus.mode_sel);
        end
    endtask

    task automatic test_back_to_back();
        int n, r0;
        @(negedge clock);
        ack_delay   = 12;
        bus.data_in = `MODE_VGA;
        exp_q.push_back(2'd0);
        r0 = req_rises;
        wait_for(1'b0, 1'b1, 40, "b2b_req1", n);
        bus.data_in = `MODE_1080p;
        exp_q.push_back(2'd2);
        ack_delay = 3;
        wait_for(1'b1, 1'b0, 80, "b2b_done1", n);
        n_checks++;
        if (bus.mode_sel !== 2'd0) begin
            n_fail++;
            $display("FAIL b2b_first: mode_sel=%0d expected 0", bus.mode_sel);
        end
        @(negedge clock);
        n_checks++;
        if (bus.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_one_idle: busy=%b expected 1", bus.busy);
        end
        wait_for(1'b1, 1'b0, 80, "b2b_done2", n);
        n_checks++;
        if (bus.mode_sel !== 2'd2 || req_rises - r0 !== 2) begin
            n_fail++;
            $display("FAIL b2b_second: mode_sel=%0d sequences=%0d expected 2 2", bus.mode_sel, req_rises - r0);
        end
    endtask

    task automatic test_settle_drop();
        int n;
        @(negedge clock);
        bus.data_in = `MODE_720p;
        exp_q.push_back(2'd1);
        wait_for(1'b0, 1'b1, 40, "sd_req", n);
        wait_for(1'b0, 1'b0, 20, "sd_ack", n);
        repeat (8) @(negedge clock);
        bus.pll_locked = 1'b0;
        repeat (4) @(negedge clock);
        n_checks++;
        if (bus.busy !== 1'b1 || bus.mode_sel !== 2'd2 || bus.lock_error !== 1'b0) begin
            n_fail++;
            $display("FAIL settle_drop_hold: busy=%b mode_sel=%0d lock_error=%b expected 1 2 0",
                     bus.busy, bus.mode_sel, bus.lock_error);
        end
        bus.pll_locked = 1'b1;
        wait_for(1'b1, 1'b0, 60, "sd_done", n);
        n_checks++;
        if (n !== 2 + 1 + SETTLE || bus.mode_sel !== 2'd1) begin
            n_fail++;
            $display("FAIL settle_restart: cycles=%0d mode_sel=%0d expected %0d 1", n, bus.mode_sel, 2 + 1 + SETTLE);
        end
    endtask

    task automatic test_reset_in_reconf();
        int n;
        logic [8:0] got;
        @(negedge clock);
        bus.data_in = `MODE_VGA;
        exp_q.push_back(2'd0);
        wait_for(1'b0, 1'b1, 40, "rr_req", n);
        #2;
        reset = 1'b1;
        #1;
        got = {bus.mode_sel, bus.reconf_req, bus.reconf_mode, bus.video_reset, bus.blank, bus.busy, bus.lock_error};
        n_checks++;
        if (got !== 9'b10_0_10_1110) begin
            n_fail++;
            $display("FAIL reset_in_reconf: got %b expected %b", got, 9'b10_0_10_1110);
        end
        exp_q.delete();
        bus.data_in = 8'h00;
        @(negedge clock);
        reset = 1'b0;
        exp_q.push_back(2'd2);
        wait_for(1'b1, 1'b0, 60, "rr_done", n);
        n_checks++;
        if (n !== 2 + 1 + SETTLE || bus.mode_sel !== 2'd2) begin
            n_fail++;
            $display("FAIL reset_relock: cycles=%0d mode_sel=%0d expected %0d 2", n, bus.mode_sel, 2 + 1 + SETTLE);
        end
    endtask

    initial begin
        test_reset();
        test_mode_change();
        test_glitch_filter();
        test_lock_timeout();
        test_back_to_back();
        test_settle_drop();
        test_reset_in_reconf();
        repeat (4) @(negedge clock);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d expected completions never seen", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
